// File: rtl/seg_pkg.sv
// seg_pkg: shared types and constants for the 7-segment display arbiter.
// Holds the FSM state encoding, the code-to-pattern table, the idle pattern
// and the round-robin search helper.
package seg_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } seg_state_t;

  // Dash shown whenever nobody owns the display.
  localparam logic [7:0] SEG_IDLE = 8'h02;

  // Entry [n] is the pattern for code n; bit 0 is the decimal point.
  // 0xA is a dash, 0xB is all-on (lamp test), 0xC..0xF are blank.
  localparam logic [15:0][7:0] SEG_TABLE = {
    8'h00, 8'h00, 8'h00, 8'h00,   // F E D C
    8'hFF, 8'h02, 8'hF7, 8'hFF,   // B A 9 8
    8'hE1, 8'hBF, 8'hB7, 8'hD3,   // 7 6 5 4
    8'hE7, 8'h6F, 8'hC1, 8'hFD    // 3 2 1 0
  };

  typedef struct packed {
    logic       vld;
    logic [1:0] idx;
  } rr_pick_t;

  // Round-robin search over three requesters, starting just after 'last'.
  function automatic rr_pick_t rr_pick(input logic [1:0] last, input logic [2:0] req);
    rr_pick_t   r;
    logic [1:0] c;
    r = '0;
    c = last;
    for (int i = 0; i < 3; i++) begin
      c = (c == 2'd2) ? 2'd0 : c + 2'd1;
      if (!r.vld && req[c]) begin
        r.vld = 1'b1;
        r.idx = c;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/seg_display_arbiter_seg_encoder.sv
// seg_encoder: combinational 4-bit display code to 8-bit segment pattern.
module seg_encoder
  import seg_pkg::*;
(
  input  logic [3:0] i_code,
  output logic [7:0] o_seg
);

  assign o_seg = SEG_TABLE[i_code];

endmodule

// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter: round-robin owner selection for a shared 7-segment
// display. Each grant holds the display for HOLD_CYCLES enabled cycles,
// then pulses done to the owner; dropping req early aborts without done.
// Optional build macro SEG_ARB_PREEMPT_EN: a rising req[0] (status channel)
// pre-empts requester 1 or 2 and takes the display straight from HOLD.
module seg_display_arbiter
  import seg_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [2:0] req,
  input  logic [3:0] code0,
  input  logic [3:0] code1,
  input  logic [3:0] code2,
  output logic [2:0] grant,
  output logic [2:0] done,
  output logic [7:0] seg
);

  localparam logic [7:0] CNT_LOAD = 8'(HOLD_CYCLES - 1);

  seg_state_t r_state;
  logic [1:0] r_last;
  logic [1:0] r_gidx;
  logic [7:0] r_cnt;
  logic [2:0] r_grant;
  logic [7:0] r_seg;

  rr_pick_t   w_pick;
  logic       w_preempt;
  logic [1:0] w_sel_idx;
  logic [3:0] w_sel_code;
  logic [7:0] w_sel_seg;
  logic       w_req_held;
  logic       w_cnt_zero;

`ifdef SEG_ARB_PREEMPT_EN
  logic r_req0_q;

  // Remember last enabled-cycle value of req[0] to detect its rising edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_req0_q <= 1'b0;
    end else if (ena) begin
      r_req0_q <= req[0];
    end
  end

  assign w_preempt = (r_state == HOLD) && (r_gidx != 2'd0) && req[0] && !r_req0_q;
`else
  assign w_preempt = 1'b0;
`endif

  assign w_pick     = rr_pick(r_last, req);
  assign w_sel_idx  = w_preempt ? 2'd0 : w_pick.idx;
  assign w_req_held = |(req & r_grant);
  assign w_cnt_zero = (r_cnt == 8'd0);

  // Code of whichever requester is about to be granted.
  always_comb begin
    w_sel_code = code0;
    case (w_sel_idx)
      2'd1:    w_sel_code = code1;
      2'd2:    w_sel_code = code2;
      default: w_sel_code = code0;
    endcase
  end

  seg_encoder u_enc (
    .i_code (w_sel_code),
    .o_seg  (w_sel_seg)
  );

  // Arbitration FSM: select in IDLE, count down in HOLD, release on expiry,
  // abort or pre-emption. Everything freezes while ena is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_last  <= 2'd2;
      r_gidx  <= 2'd0;
      r_cnt   <= 8'd0;
      r_grant <= 3'b000;
      r_seg   <= SEG_IDLE;
    end else if (ena) begin
      case (r_state)
        IDLE: begin
          if (w_pick.vld) begin
            r_state <= HOLD;
            r_gidx  <= w_sel_idx;
            r_grant <= 3'b001 << w_sel_idx;
            r_seg   <= w_sel_seg;
            r_cnt   <= CNT_LOAD;
          end
        end
        HOLD: begin
          if (w_preempt) begin
            r_last  <= r_gidx;
            r_gidx  <= 2'd0;
            r_grant <= 3'b001;
            r_seg   <= w_sel_seg;
            r_cnt   <= CNT_LOAD;
          end else if (!w_req_held || w_cnt_zero) begin
            r_state <= IDLE;
            r_last  <= r_gidx;
            r_grant <= 3'b000;
            r_seg   <= SEG_IDLE;
            r_cnt   <= 8'd0;
          end else begin
            r_cnt   <= r_cnt - 8'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_grant <= 3'b000;
          r_seg   <= SEG_IDLE;
        end
      endcase
    end
  end

  // done only on a genuine completion: counter expired, owner still
  // requesting, clock enabled and not being pre-empted on this edge.
  assign done  = (ena && (r_state == HOLD) && w_cnt_zero && w_req_held && !w_preempt)
               ? r_grant : 3'b000;
  assign grant = r_grant;
  assign seg   = r_seg;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter with HOLD_CYCLES=4.
module tb_seg_display_arbiter;

  localparam int HC = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [2:0] req;
  logic [3:0] code0, code1, code2;
  logic [2:0] grant;
  logic [2:0] done;
  logic [7:0] seg;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_tab [16];
  logic [2:0] exp_g   [4];
  logic [7:0] exp_s   [4];

  seg_display_arbiter #(.HOLD_CYCLES(HC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .req   (req),
    .code0 (code0),
    .code1 (code1),
    .code2 (code2),
    .grant (grant),
    .done  (done),
    .seg   (seg)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ena   = 1'b1;
    req   = 3'b000;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_tab = '{8'hFD, 8'hC1, 8'h6F, 8'hE7, 8'hD3, 8'hB7, 8'hBF, 8'hE1,
                8'hFF, 8'hF7, 8'h02, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
    exp_g   = '{3'b001, 3'b010, 3'b100, 3'b001};
    exp_s   = '{8'hC1, 8'h6F, 8'hE7, 8'hC1};
    code0 = 4'h0; code1 = 4'h0; code2 = 4'h0;

    // Reset with ena low: reset must still win.
    rst_n = 1'b0; ena = 1'b0; req = 3'b000;
    step(); step();
    chk("rst_grant", 8'(grant), 8'h00);
    chk("rst_done",  8'(done),  8'h00);
    chk("rst_seg",   seg,       8'h02);
    rst_n = 1'b1; ena = 1'b1;

    // Idle for 20 cycles with no requests.
    for (int i = 0; i < 20; i++) begin
      step();
      chk("idle_seg",   seg,       8'h02);
      chk("idle_grant", 8'(grant), 8'h00);
    end

    // Single grant to requester 0, code 1; code change mid-hold ignored.
    req = 3'b001; code0 = 4'h1;
    for (int k = 1; k <= HC; k++) begin
      step();
      chk("r0_grant", 8'(grant), 8'h01);
      chk("r0_seg",   seg,       8'hC1);
      chk("r0_done",  8'(done),  (k == HC) ? 8'h01 : 8'h00);
      if (k == 2) code0 = 4'h8;
    end
    req = 3'b000;
    #1;
    chk("abort_at_zero_done", 8'(done), 8'h00);
    step();
    chk("r0_rel_grant", 8'(grant), 8'h00);
    chk("r0_rel_seg",   seg,       8'h02);
    chk("r0_rel_done",  8'(done),  8'h00);

    // Round-robin with all three requesting.
    do_reset();
    req = 3'b111; code0 = 4'h1; code1 = 4'h2; code2 = 4'h3;
    for (int t = 0; t < 4; t++) begin
      for (int k = 1; k <= HC; k++) begin
        step();
        chk("rr_grant", 8'(grant), 8'(exp_g[t]));
        chk("rr_seg",   seg,       exp_s[t]);
        chk("rr_done",  8'(done),  (k == HC) ? 8'(exp_g[t]) : 8'h00);
      end
      step();
      chk("rr_idle_grant", 8'(grant), 8'h00);
      chk("rr_idle_seg",   seg,       8'h02);
    end
    req = 3'b000;
    step();

    // Abort: req[1] drops mid-hold; last_granted then points at 1.
    do_reset();
    req = 3'b010; code1 = 4'h5;
    step();
    chk("ab_grant", 8'(grant), 8'h02);
    chk("ab_seg",   seg,       8'hB7);
    req = 3'b000;
    step();
    chk("ab_rel_grant", 8'(grant), 8'h00);
    chk("ab_rel_seg",   seg,       8'h02);
    chk("ab_rel_done",  8'(done),  8'h00);
    req = 3'b011;
    step();
    chk("ab_next_grant", 8'(grant), 8'h01);
    req = 3'b000;
    step();
    chk("ab_next_rel", 8'(grant), 8'h00);

    // Enable freeze mid-hold: done slips by 5 cycles.
    do_reset();
    req = 3'b001; code0 = 4'h7;
    step();
    chk("frz_grant", 8'(grant), 8'h01);
    chk("frz_seg",   seg,       8'hE1);
    step();
    ena = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("frz_hold_grant", 8'(grant), 8'h01);
      chk("frz_hold_seg",   seg,       8'hE1);
      chk("frz_hold_done",  8'(done),  8'h00);
    end
    ena = 1'b1;
    step();
    chk("frz_pre_done", 8'(done), 8'h00);
    step();
    chk("frz_done",     8'(done), 8'h01);
    req = 3'b000;
    step();
    chk("frz_rel_seg", seg, 8'h02);

    // Reset in the middle of a hold abandons the grant.
    req = 3'b100; code2 = 4'h9;
    step();
    chk("rh_grant", 8'(grant), 8'h04);
    chk("rh_seg",   seg,       8'hF7);
    step();
    rst_n = 1'b0;
    step();
    chk("rh_rst_grant", 8'(grant), 8'h00);
    chk("rh_rst_seg",   seg,       8'h02);
    chk("rh_rst_done",  8'(done),  8'h00);
    rst_n = 1'b1; req = 3'b110;
    step();
    chk("rh_after_grant", 8'(grant), 8'h02);
    req = 3'b000;
    step();

    // Full encoder sweep through requester 2.
    for (int c = 0; c < 16; c++) begin
      req = 3'b100; code2 = 4'(c);
      step();
      chk("enc_seg",   seg,       exp_tab[c]);
      chk("enc_grant", 8'(grant), 8'h04);
      step(); step(); step();
      chk("enc_done", 8'(done), 8'h04);
      req = 3'b000;
      step();
      chk("enc_rel_seg", seg, 8'h02);
    end

    // Requester 0 rising while requester 2 holds.
    do_reset();
    req = 3'b100; code2 = 4'hB;
    step();
    chk("pe_grant2", 8'(grant), 8'h04);
    chk("pe_seg2",   seg,       8'hFF);
    req = 3'b101; code0 = 4'hA;
    #1;
    chk("pe_done_pre", 8'(done), 8'h00);
    step();
`ifdef SEG_ARB_PREEMPT_EN
    chk("pe_grant0", 8'(grant), 8'h01);
    chk("pe_seg0",   seg,       8'h02);
    chk("pe_done",   8'(done),  8'h00);
    step(); step(); step();
    chk("pe_done0",  8'(done),  8'h01);
`else
    chk("np_grant2", 8'(grant), 8'h04);
    chk("np_seg2",   seg,       8'hFF);
    step(); step();
    chk("np_done2",  8'(done),  8'h04);
`endif
    req = 3'b000;
    step();
    chk("pe_rel_seg", seg, 8'h02);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
